// File: rtl/pipeline_hazard_controller_if.sv
// rtl/pipeline_hazard_controller_if.sv - pipeline status in, stall/flush/redirect/memory controls out
interface pipeline_hazard_controller_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 id_valid;
   logic [31:0]          id_instruction;
   logic                 ex_valid;
   logic [4:0]           ex_rd;
   logic                 ex_mem_read;
   logic                 ex_mem_access;
   logic                 ex_branch_taken;
   logic                 mem_ready;

   logic                 pc_write;
   logic                 ifid_write;
   logic                 ifid_flush;
   logic                 idex_bubble;
   logic                 ex_hold;
   logic                 pc_src;
   logic                 mem_req;
   logic [1:0]           ctrl_state;
   logic [CNT_WIDTH-1:0] stall_count;

   modport master (
      output id_valid, id_instruction, ex_valid, ex_rd, ex_mem_read,
             ex_mem_access, ex_branch_taken, mem_ready,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold,
             pc_src, mem_req, ctrl_state, stall_count
   );

   modport slave (
      input  id_valid, id_instruction, ex_valid, ex_rd, ex_mem_read,
             ex_mem_access, ex_branch_taken, mem_ready,
      output pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold,
             pc_src, mem_req, ctrl_state, stall_count
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush/redirect sequencing and data-memory handshake for the 2.5-stage RV64 pipeline
module pipeline_hazard_controller #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic i_clk,
   input  logic i_reset,
   pipeline_hazard_controller_if.slave io_hz
);
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   localparam logic [3:0]           LP_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam bit                   LP_USE_FLUSH  = (FLUSH_CYCLES > 1);
   localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX    = '1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [3:0]           r_flush_cnt;
   logic [3:0]           w_flush_cnt_nxt;
   logic [CNT_WIDTH-1:0] r_stall_count;

   logic [6:0] w_opcode;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic       w_rs1_used;
   logic       w_rs2_used;
   logic       w_load_use;
   logic       w_mem_op;
   logic       w_unused_instr;

   logic w_pc_write;
   logic w_ifid_write;
   logic w_ifid_flush;
   logic w_idex_bubble;
   logic w_ex_hold;
   logic w_pc_src;
   logic w_mem_req;

   assign w_opcode       = io_hz.id_instruction[6:0];
   assign w_rs1          = io_hz.id_instruction[19:15];
   assign w_rs2          = io_hz.id_instruction[24:20];
   assign w_unused_instr = ^{io_hz.id_instruction[31:25], io_hz.id_instruction[14:7]};

   always_comb begin
      w_rs1_used = 1'b0;
      w_rs2_used = 1'b0;
      case (w_opcode)
         7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011: begin
            w_rs1_used = 1'b1;
            w_rs2_used = 1'b1;
         end
         7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
            w_rs1_used = 1'b1;
         end
         default: begin
            w_rs1_used = 1'b0;
            w_rs2_used = 1'b0;
         end
      endcase
   end

   // ex_rd != 0 covers the x0 exemption: a used x0 source can only match a zero ex_rd.
   assign w_load_use = io_hz.ex_valid && io_hz.ex_mem_read && (io_hz.ex_rd != 5'd0) &&
                       io_hz.id_valid &&
                       ((w_rs1_used && (w_rs1 == io_hz.ex_rd)) ||
                        (w_rs2_used && (w_rs2 == io_hz.ex_rd)));

   assign w_mem_op = io_hz.ex_valid && io_hz.ex_mem_access;

   always_comb begin
      w_pc_write      = 1'b1;
      w_ifid_write    = 1'b1;
      w_ifid_flush    = 1'b0;
      w_idex_bubble   = 1'b0;
      w_ex_hold       = 1'b0;
      w_pc_src        = 1'b0;
      w_mem_req       = 1'b0;
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;

      if (i_reset) begin
         w_pc_write      = 1'b0;
         w_ifid_write    = 1'b0;
         w_idex_bubble   = 1'b1;
         w_state_nxt     = ST_RUN;
         w_flush_cnt_nxt = 4'd0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (io_hz.ex_valid && io_hz.ex_branch_taken) begin
                  w_pc_src      = 1'b1;
                  w_ifid_flush  = 1'b1;
                  w_idex_bubble = 1'b1;
                  if (LP_USE_FLUSH) begin
                     w_state_nxt     = ST_FLUSH;
                     w_flush_cnt_nxt = LP_FLUSH_LOAD;
                  end
               end else begin
                  w_mem_req = w_mem_op;
                  if (w_mem_op && !io_hz.mem_ready) begin
                     w_pc_write   = 1'b0;
                     w_ifid_write = 1'b0;
                     w_ex_hold    = 1'b1;
                     w_state_nxt  = ST_MEM_WAIT;
                  end else if (w_load_use) begin
                     w_pc_write    = 1'b0;
                     w_ifid_write  = 1'b0;
                     w_idex_bubble = 1'b1;
                  end
               end
            end
            ST_MEM_WAIT: begin
               w_mem_req    = 1'b1;
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b0;
               w_ex_hold    = 1'b1;
               if (io_hz.mem_ready) begin
                  w_state_nxt = ST_RUN;
                  // Load finishing with a dependent in ID: let EX advance, bubble behind it.
                  if (w_load_use) begin
                     w_ex_hold     = 1'b0;
                     w_idex_bubble = 1'b1;
                  end
               end
            end
            ST_FLUSH: begin
               w_ifid_flush  = 1'b1;
               w_idex_bubble = 1'b1;
               if (r_flush_cnt <= 4'd1) begin
                  w_state_nxt     = ST_RUN;
                  w_flush_cnt_nxt = 4'd0;
               end else begin
                  w_flush_cnt_nxt = r_flush_cnt - 4'd1;
               end
            end
            default: begin
               w_state_nxt     = ST_RUN;
               w_flush_cnt_nxt = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stall_count <= '0;
      end else if (!w_pc_write && (r_stall_count != LP_CNT_MAX)) begin
         r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      end
   end

   assign io_hz.pc_write    = w_pc_write;
   assign io_hz.ifid_write  = w_ifid_write;
   assign io_hz.ifid_flush  = w_ifid_flush;
   assign io_hz.idex_bubble = w_idex_bubble;
   assign io_hz.ex_hold     = w_ex_hold;
   assign io_hz.pc_src      = w_pc_src;
   assign io_hz.mem_req     = w_mem_req;
   assign io_hz.ctrl_state  = i_reset ? 2'd0 : r_state;
   assign io_hz.stall_count = i_reset ? '0 : r_stall_count;
endmodule
